// File: rtl/exception_ctrl_pkg.sv
// Shared CP0 definitions: exception codes, register addresses, vectors and FSM states.
package exception_ctrl_pkg;

  // Exception codes as presented by the exception unit
  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_TR   = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // General exception vector (BEV=1)
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Reset value of Status (BEV set) and software-writable field masks
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Bit positions inside Status / Cause
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [31:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exception_ctrl_timer.sv
// CP0 Count/Compare timer with sticky interrupt flag.
module cp0_timer
  import exception_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_nxt_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        toggle_q, toggle_d;
  logic        timer_int_q, timer_int_d;

  // Half-rate counting, software writes and the sticky compare-match flag
  always_comb begin
    count_d   = count_q;
    toggle_d  = ~toggle_q;
    compare_d = compare_q;
    if (count_we_i) begin
      // A software write restarts the half-rate phase as well
      count_d  = wdata_i;
      toggle_d = 1'b0;
    end else if (toggle_q) begin
      count_d = count_q + 32'd1;
    end

    if (compare_we_i) begin
      compare_d = wdata_i;
    end

    timer_int_d = timer_int_q;
    if (compare_we_i) begin
      timer_int_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_int_d = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      toggle_q    <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      toggle_q    <= toggle_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  // Cause.IP7 is loaded from the next flag value so it tracks the flag register exactly
  assign timer_int_nxt_o = timer_int_d;

endmodule

// File: rtl/exception_ctrl.sv
// CP0 exception controller: event acceptance, CP0 register file, flush/redirect.
module exception_ctrl
  import exception_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] exc_code_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] bad_addr_i,
  input  logic        stall_i,
  input  logic [4:0]  hw_int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] cp0_status_o,
  output logic [31:0] cp0_cause_o,
  output logic [31:0] cp0_epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  state_e      state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic        accept;
  logic        is_eret;
  logic        exl;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] count, compare;
  logic        timer_int_nxt;

  // Decode the incoming event and software writes
  always_comb begin
    accept     = (state_q == ST_IDLE) && (exc_code_i != EXC_NONE) && !stall_i;
    is_eret    = (exc_code_i == EXC_ERET);
    exl        = status_q[STATUS_EXL];
    wr_count   = we_i && (waddr_i == CP0_COUNT);
    wr_compare = we_i && (waddr_i == CP0_COMPARE);
    wr_status  = we_i && (waddr_i == CP0_STATUS);
    wr_cause   = we_i && (waddr_i == CP0_CAUSE);
    wr_epc     = we_i && (waddr_i == CP0_EPC);
  end

  cp0_timer u_timer (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .count_we_i      (wr_count),
    .compare_we_i    (wr_compare),
    .wdata_i         (wdata_i),
    .count_o         (count),
    .compare_o       (compare),
    .timer_int_nxt_o (timer_int_nxt)
  );

  // Next-state: software writes first, then the accepted event overrides per field
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    new_pc_d   = 32'd0;
    state_d    = ST_IDLE;

    if (wr_status) begin
      status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
    end
    if (wr_cause) begin
      cause_d = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
    end
    if (wr_epc) begin
      epc_d = wdata_i;
    end

    // Pending-interrupt bits are sampled every cycle
    cause_d[15:10] = {timer_int_nxt, hw_int_i};

    if (accept) begin
      state_d = ST_FLUSH;
      if (is_eret) begin
        // Return target is the EPC held before this edge, even if MTC0 rewrites it now
        new_pc_d              = epc_q;
        status_d[STATUS_EXL]  = 1'b0;
      end else begin
        new_pc_d              = EXC_VECTOR;
        status_d[STATUS_EXL]  = 1'b1;
        cause_d[6:2]          = exc_code_i[4:0];
        // A nested exception keeps the original return point
        if (!exl) begin
          epc_d             = mem_in_ds_i ? (mem_pc_i - 32'd4) : mem_pc_i;
          cause_d[CAUSE_BD] = mem_in_ds_i;
        end
        if (is_addr_exc(exc_code_i)) begin
          badvaddr_d = bad_addr_i;
        end
      end
    end
  end

  // CP0 registers, FSM state and redirect target
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      new_pc_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      new_pc_q   <= new_pc_d;
    end
  end

  // MFC0 read port: current register contents, unmapped numbers read zero
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count;
      CP0_COMPARE:  rdata_o = compare;
      CP0_STATUS:   rdata_o = status_q;
      CP0_CAUSE:    rdata_o = cause_q;
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign cp0_status_o = status_q;
  assign cp0_cause_o  = cause_q;
  assign cp0_epc_o    = epc_q;
  assign flush_o      = (state_q == ST_FLUSH);
  assign new_pc_o     = new_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomised and directed bench for exception_ctrl with a rule-level reference model.
module tb_exception_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] exc_code_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_ds_i;
  logic [31:0] bad_addr_i;
  logic        stall_i;
  logic [4:0]  hw_int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] cp0_status_o;
  logic [31:0] cp0_cause_o;
  logic [31:0] cp0_epc_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  exception_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .exc_code_i   (exc_code_i),
    .mem_pc_i     (mem_pc_i),
    .mem_in_ds_i  (mem_in_ds_i),
    .bad_addr_i   (bad_addr_i),
    .stall_i      (stall_i),
    .hw_int_i     (hw_int_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .raddr_i      (raddr_i),
    .rdata_o      (rdata_o),
    .cp0_status_o (cp0_status_o),
    .cp0_cause_o  (cp0_cause_o),
    .cp0_epc_o    (cp0_epc_o),
    .flush_o      (flush_o),
    .new_pc_o     (new_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference model: architectural registers; Count is base value plus half the edges since it was set
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_compare, m_newpc;
  logic [31:0] m_cnt_base, m_cnt_since;
  logic        m_tint, m_flush;

  function automatic logic [31:0] m_count();
    return m_cnt_base + (m_cnt_since / 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: predict from the rules, advance, then compare every visible output
  task automatic tick();
    logic [31:0] st, ca, ep, bv, cmp, base, since, npc;
    logic        ti, fl, acc;
    st = m_status; ca = m_cause; ep = m_epc; bv = m_badv; cmp = m_compare;
    base = m_cnt_base; since = m_cnt_since + 1; ti = m_tint; npc = 32'd0;
    acc = !m_flush && (exc_code_i != 0) && !stall_i;
    if (we_i && waddr_i == 5'd12) st = {m_status[31:16], wdata_i[15:8], m_status[7:2], wdata_i[1:0]};
    if (we_i && waddr_i == 5'd13) ca[9:8] = wdata_i[9:8];
    if (we_i && waddr_i == 5'd14) ep = wdata_i;
    if (we_i && waddr_i == 5'd9) begin base = wdata_i; since = 0; end
    if (we_i && waddr_i == 5'd11) begin cmp = wdata_i; ti = 1'b0; end
    else if (m_count() == m_compare && m_compare != 0) ti = 1'b1;
    ca[15] = ti;
    ca[14:10] = hw_int_i;
    if (acc) begin
      if (exc_code_i == 32'hE) begin
        npc = m_epc;
        st[1] = 1'b0;
      end else begin
        npc = 32'hBFC00380;
        st[1] = 1'b1;
        ca[6:2] = exc_code_i[4:0];
        if (!m_status[1]) begin
          ep = mem_in_ds_i ? mem_pc_i - 4 : mem_pc_i;
          ca[31] = mem_in_ds_i;
        end
        if (exc_code_i == 4 || exc_code_i == 5) bv = bad_addr_i;
      end
    end
    fl = acc;
    if (rst_i) begin
      st = 32'h00400000; ca = 0; ep = 0; bv = 0; cmp = 0; base = 0; since = 0;
      ti = 0; fl = 0; npc = 0;
    end
    @(posedge clk_i);
    #1;
    m_status = st; m_cause = ca; m_epc = ep; m_badv = bv; m_compare = cmp;
    m_cnt_base = base; m_cnt_since = since; m_tint = ti; m_flush = fl; m_newpc = npc;
    chk("flush", {31'd0, flush_o}, {31'd0, m_flush});
    if (m_flush) chk("new_pc", new_pc_o, m_newpc);
    chk("status", cp0_status_o, m_status);
    chk("cause", cp0_cause_o, m_cause);
    chk("epc", cp0_epc_o, m_epc);
    chk("rdata", rdata_o, m_read(raddr_i));
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr_i = a;
    #1;
    chk(tag, rdata_o, exp);
  endtask

  task automatic idle_inputs();
    rst_i = 0; exc_code_i = 0; mem_pc_i = 0; mem_in_ds_i = 0; bad_addr_i = 0;
    stall_i = 0; hw_int_i = 0; we_i = 0; waddr_i = 0; wdata_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 0;
  endtask

  logic [31:0] codes [9] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hD, 32'hE};
  logic [4:0]  regs  [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

  logic [31:0] snap_cause, snap_epc;

  initial begin
    idle_inputs();
    raddr_i = 5'd12;
    m_status = 'x; m_cause = 'x; m_epc = 'x; m_badv = 'x; m_compare = 'x;
    m_cnt_base = 0; m_cnt_since = 0; m_tint = 0; m_flush = 0; m_newpc = 0;
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;

    // Reset state
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_status", cp0_status_o, 32'h00400000);
    chk("rst_cause", cp0_cause_o, 32'd0);
    chk("rst_epc", cp0_epc_o, 32'd0);
    rd_chk("rst_badv", 5'd8, 32'd0);
    rd_chk("rst_compare", 5'd11, 32'd0);

    // Syscall from a normal slot
    exc_code_i = 32'h8; mem_pc_i = 32'hBFC00100; mem_in_ds_i = 0;
    tick();
    chk("sys_flush", {31'd0, flush_o}, 32'd1);
    chk("sys_newpc", new_pc_o, 32'hBFC00380);
    chk("sys_epc", cp0_epc_o, 32'hBFC00100);
    chk("sys_exccode", {27'd0, cp0_cause_o[6:2]}, 32'd8);
    chk("sys_exl", {31'd0, cp0_status_o[1]}, 32'd1);
    // Event still present during FLUSH must be ignored
    tick();
    chk("sys_flush_end", {31'd0, flush_o}, 32'd0);
    exc_code_i = 0;
    tick();

    // Address error in a delay slot
    mtc0(5'd12, 32'd0);
    chk("clr_exl", cp0_status_o, 32'h00400000);
    exc_code_i = 32'h4; mem_pc_i = 32'h80000010; mem_in_ds_i = 1; bad_addr_i = 32'h1235;
    tick();
    exc_code_i = 0; mem_in_ds_i = 0;
    chk("adel_epc", cp0_epc_o, 32'h8000000C);
    chk("adel_bd", {31'd0, cp0_cause_o[31]}, 32'd1);
    rd_chk("adel_badv", 5'd8, 32'h1235);
    tick();
    // BadVAddr ignores software writes
    mtc0(5'd8, 32'hDEADBEEF);
    rd_chk("badv_ro", 5'd8, 32'h1235);

    // ERET back to EPC, then nested entry keeps EPC
    mtc0(5'd14, 32'h80001000);
    exc_code_i = 32'hE;
    tick();
    exc_code_i = 0;
    chk("eret_flush", {31'd0, flush_o}, 32'd1);
    chk("eret_newpc", new_pc_o, 32'h80001000);
    chk("eret_exl", {31'd0, cp0_status_o[1]}, 32'd0);
    tick();
    mtc0(5'd12, 32'h2);
    exc_code_i = 32'h8; mem_pc_i = 32'h00001234;
    tick();
    exc_code_i = 0;
    chk("nest_epc", cp0_epc_o, 32'h80001000);
    tick();

    // Stalled overflow is held off until release
    snap_cause = cp0_cause_o; snap_epc = cp0_epc_o;
    exc_code_i = 32'hC; stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flush", {31'd0, flush_o}, 32'd0);
      chk("stall_cause", cp0_cause_o, snap_cause);
      chk("stall_epc", cp0_epc_o, snap_epc);
    end
    stall_i = 0;
    tick();
    exc_code_i = 0;
    chk("release_flush", {31'd0, flush_o}, 32'd1);
    chk("ov_exccode", {27'd0, cp0_cause_o[6:2]}, 32'hC);
    tick();

    // Timer match raises Cause.IP7, Compare write clears it
    mtc0(5'd11, 32'd4);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    rd_chk("cnt_at_8", 5'd9, 32'd4);
    chk("ip7_not_yet", {31'd0, cp0_cause_o[15]}, 32'd0);
    tick();
    chk("ip7_set", {31'd0, cp0_cause_o[15]}, 32'd1);
    tick();
    chk("ip7_sticky", {31'd0, cp0_cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'h10);
    chk("ip7_clear", {31'd0, cp0_cause_o[15]}, 32'd0);

    // Reset during FLUSH aborts the pulse
    exc_code_i = 32'h9;
    tick();
    exc_code_i = 0;
    chk("bp_flush", {31'd0, flush_o}, 32'd1);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("rst_abort_flush", {31'd0, flush_o}, 32'd0);
    rd_chk("rst_abort_status", 5'd12, 32'h00400000);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_i       = ($urandom_range(0, 199) == 0);
      stall_i     = ($urandom_range(0, 2) == 0);
      exc_code_i  = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(0, 8)] : 32'd0;
      mem_pc_i    = $urandom & 32'hFFFF_FFFC;
      mem_in_ds_i = $urandom_range(0, 1) == 1;
      bad_addr_i  = $urandom;
      hw_int_i    = 5'($urandom);
      we_i        = ($urandom_range(0, 3) == 0);
      waddr_i     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : regs[$urandom_range(0, 5)];
      wdata_i     = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      raddr_i     = regs[$urandom_range(0, 6)];
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  core clock; rst_i  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: exc_code_i  in  32  prioritised exception code from the exception unit (0 none; 1 Int; 4 AdEL; 5 AdES; 8 Sys; 9 Bp; A RI; C Ov; D Tr; E ERET).
REQ-003 SHALL have ports: mem_pc_i  in  32  PC of the MEM-stage instruction; mem_in_ds_i  in  1  that instruction is in a delay slot; bad_addr_i  in  32  faulting address.
REQ-004 SHALL have ports: stall_i  in  1  pipeline stalled; hw_int_i  in  5  external interrupt lines.
REQ-005 SHALL have ports: we_i  in  1  MTC0 write enable; waddr_i  in  5  and wdata_i  in  32  write register and data; raddr_i  in  5  MFC0 read register; rdata_o  out  32  read data.
REQ-006 SHALL have ports: cp0_status_o  out  32  Status; cp0_cause_o  out  32  Cause; cp0_epc_o  out  32  EPC.
REQ-007 SHALL have ports: flush_o  out  1  pipeline flush pulse; new_pc_o  out  32  redirect target, valid while flush_o=1.

Function
REQ-010 SHALL implement FSM IDLE -> FLUSH -> IDLE with no other states.
REQ-011 In IDLE, SHALL accept an event when exc_code_i!=0 and stall_i=0; while stall_i=1 the event SHALL NOT be taken and no CP0 register SHALL change from it.
REQ-012 On acceptance in cycle N, CP0 updates SHALL occur at the end of cycle N, and flush_o=1 with new_pc_o valid SHALL hold for exactly cycle N+1 (state FLUSH).
REQ-013 In FLUSH, exc_code_i SHALL be ignored, and the FSM SHALL return to IDLE unconditionally.
REQ-014 Non-ERET entry: new_pc_o=0xBFC00380; Cause[6:2]=exc_code_i[4:0]; Status[1] (EXL)=1.
REQ-015 Non-ERET entry with Status.EXL=0: EPC=mem_pc_i-4 and Cause[31] (BD)=1 if mem_in_ds_i=1, else EPC=mem_pc_i and BD=0. With EXL=1, EPC and BD SHALL be unchanged.
REQ-016 For codes 4 and 5, BadVAddr SHALL be set to bad_addr_i.
REQ-017 ERET (0xE): new_pc_o=EPC value before the edge; Status.EXL=0; Cause, EPC and BadVAddr unchanged.
REQ-018 Cause[15:10] SHALL be loaded every cycle with {timer_int, hw_int_i}, where timer_int is the sticky timer flag.
REQ-019 Count SHALL increment by 1 every second clock, wrapping 0xFFFFFFFF->0. timer_int SHALL be set when Count==Compare and Compare!=0, and cleared by an MTC0 to Compare.
REQ-020 MTC0 writable fields: Count (reg 9, also clears the half-rate toggle), Compare (11), Status (12: bits 15:8, 1, 0), Cause (13: bits 9:8 only), EPC (14). BadVAddr (8) SHALL be read-only.
REQ-021 If MTC0 and an accepted event hit the same register in the same cycle, the event update SHALL win per field. MTC0 to Count SHALL win over the increment.
REQ-022 rdata_o SHALL be a combinational read of the current register value; unmapped addresses SHALL read 0. There SHALL be no write-to-read bypass.
REQ-023 cp0_status_o, cp0_cause_o and cp0_epc_o SHALL be direct register outputs with no combinational path from inputs.

Reset
REQ-030 On rst_i=1 at a clock edge: Status=0x00400000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, timer_int=0, toggle=0, FSM=IDLE, flush_o=0, new_pc_o=0.
REQ-031 Reset during FLUSH SHALL abort the pulse, so flush_o=0 in the next cycle.

Structure
REQ-040 A shared package SHALL hold the exception code constants, CP0 register addresses (8, 9, 11, 12, 13, 14), the vector 0xBFC00380 and the FSM state enum.
REQ-041 Count/Compare/timer_int SHALL be a sub-module cp0_timer, instantiated once.

Verification
REQ-050 Syscall: exc_code_i=8, mem_pc_i=0xBFC00100, mem_in_ds_i=0, Status.EXL=0 -> next cycle flush_o=1, new_pc_o=0xBFC00380; EPC=0xBFC00100, Cause[6:2]=8, EXL=1; flush_o=0 the cycle after.
REQ-051 Delay-slot AdEL: code 4, mem_pc_i=0x80000010, mem_in_ds_i=1, bad_addr_i=0x1235 -> EPC=0x8000000C, BD=1, BadVAddr=0x1235.
REQ-052 Stall hold: code 0xC with stall_i=1 for 3 cycles, then stall_i=0 -> no flush and no CP0 change for 3 cycles, flush_o=1 exactly one cycle after release.
REQ-053 ERET: EPC=0x80001000, EXL=1, code 0xE -> new_pc_o=0x80001000, EXL=0. Nested entry with EXL=1 leaves EPC unchanged.
REQ-054 Timer: MTC0 Compare=4, Count=0 -> Count reaches 4 after 8 cycles, then Cause[15]=1. MTC0 Compare=0x10 -> Cause[15]=0 next cycle.
REQ-055 Reset: rst_i=1 in the FLUSH cycle -> flush_o=0 next cycle, Status reads 0x00400000.
